music_play_ctrl: RTL and testbench

- Playback sequencer for the music RAM. It steps the RAM read address at a fixed note rate and handles play/pause/stop/next/prev keys across a small track list.
- It drives the ram_addr_out / music_len pair consumed by the elapsed/total time display (4 addresses = 1 s) and the absolute RAM read address for the tone datapath.
- The track table is an external combinational ROM indexed by track_sel.

---
 rtl/music_play_ctrl_if.sv | 32 +++
 rtl/music_play_ctrl.sv | 160 ++++++++++++++++
 tb/tb_music_play_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/music_play_ctrl_if.sv
// Key/ROM/playback signal bundle between the music playback sequencer and its neighbours.
// The master side drives the keys and ROM data; the slave side is the sequencer.
interface music_play_ctrl_if #(
  parameter int ADDR_W    = 12,
  parameter int TRACK_NUM = 4
);
  localparam int SEL_W = $clog2(TRACK_NUM);

  logic              key_play;
  logic              key_stop;
  logic              key_next;
  logic              key_prev;
  logic              loop_en;
  logic [ADDR_W-1:0] track_base;
  logic [ADDR_W-1:0] track_len;
  logic [SEL_W-1:0]  track_sel;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] music_len;
  logic              playing;
  logic              note_tick;

  modport master (
    output key_play, key_stop, key_next, key_prev, loop_en, track_base, track_len,
    input  track_sel, ram_addr_out, rd_addr, music_len, playing, note_tick
  );

  modport slave (
    input  key_play, key_stop, key_next, key_prev, loop_en, track_base, track_len,
    output track_sel, ram_addr_out, rd_addr, music_len, playing, note_tick
  );
endinterface

// File: rtl/music_play_ctrl.sv
// Music RAM playback sequencer: steps the read address at NOTE_HZ and handles
// play/pause/stop/next/prev over a small track list described by an external ROM.
module music_play_ctrl #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int NOTE_HZ   = 4,
  parameter int TRACK_NUM = 4,
  parameter int ADDR_W    = 12
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  music_play_ctrl_if.slave   bus
);
  localparam int DIV   = CLK_FREQ / NOTE_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SEL_W = $clog2(TRACK_NUM);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(TRACK_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, PAUSE} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;

  logic [SEL_W-1:0]  sel_inc, sel_dec;
  logic              div_term, at_end;

  // Explicit wrap so non-power-of-two track counts still cycle correctly.
  assign sel_inc  = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
  assign sel_dec  = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
  assign div_term = (div_q == DIV_LAST);
  assign at_end   = (len_q == '0) || (addr_q >= (len_q - ADDR_W'(1)));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    len_d   = len_q;
    base_d  = base_q;
    div_d   = div_q;
    tick_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.key_stop) begin
          state_d = IDLE;
        end else if (bus.key_next) begin
          sel_d = sel_inc;
        end else if (bus.key_prev) begin
          sel_d = sel_dec;
        end else if (bus.key_play) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        len_d  = bus.track_len;
        base_d = bus.track_base;
        addr_d = '0;
        rd_d   = bus.track_base;
        if (bus.track_len == '0) begin
          state_d = IDLE;
        end else begin
          tick_d  = 1'b1;
          state_d = PLAY;
        end
      end

      PLAY: begin
        div_d = div_term ? '0 : div_q + DIV_W'(1);
        // Keys take precedence over a coinciding divider terminal.
        if (bus.key_stop) begin
          state_d = IDLE;
          addr_d  = '0;
          rd_d    = base_q;
        end else if (bus.key_next) begin
          sel_d   = sel_inc;
          state_d = LOAD;
        end else if (bus.key_prev) begin
          sel_d   = sel_dec;
          state_d = LOAD;
        end else if (bus.key_play) begin
          state_d = PAUSE;
        end else if (div_term) begin
          if (!at_end) begin
            addr_d = addr_q + ADDR_W'(1);
            rd_d   = rd_q + ADDR_W'(1);
            tick_d = 1'b1;
          end else if (bus.loop_en) begin
            state_d = LOAD;
          end else if (sel_q != SEL_LAST) begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = LOAD;
          end else begin
            sel_d   = '0;
            addr_d  = '0;
            state_d = IDLE;
          end
        end
      end

      PAUSE: begin
        if (bus.key_stop) begin
          state_d = IDLE;
          addr_d  = '0;
          rd_d    = base_q;
        end else if (bus.key_next) begin
          sel_d   = sel_inc;
          state_d = LOAD;
        end else if (bus.key_prev) begin
          sel_d   = sel_dec;
          state_d = LOAD;
        end else if (bus.key_play) begin
          state_d = PLAY;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == IDLE || state_d == LOAD || state_q == LOAD) begin
      div_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      base_q  <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      base_q  <= base_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.track_sel    = sel_q;
  assign bus.ram_addr_out = addr_q;
  assign bus.rd_addr      = rd_q;
  assign bus.music_len    = len_q;
  assign bus.playing      = (state_q == PLAY);
  assign bus.note_tick    = tick_q;
endmodule

// File: tb/tb_music_play_ctrl.sv
// Directed bench for music_play_ctrl with DIV=10 and a 4-track ROM (track 2 empty).
module tb_music_play_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  music_play_ctrl_if #(.ADDR_W(12), .TRACK_NUM(4)) bus ();

  music_play_ctrl #(
    .CLK_FREQ(40), .NOTE_HZ(4), .TRACK_NUM(4), .ADDR_W(12)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );

  // Track ROM: base = k*256, len = 8 except track 2 which is empty.
  always_comb begin
    bus.track_base = {2'b00, bus.track_sel, 8'h00};
    bus.track_len  = (bus.track_sel == 2'd2) ? 12'd0 : 12'd8;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.key_play = 1'b0; bus.key_stop = 1'b0; bus.key_next = 1'b0; bus.key_prev = 1'b0;
    bus.loop_en = 1'b0;
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (bus.track_sel !== 2'd0 || bus.ram_addr_out !== 12'd0 || bus.rd_addr !== 12'd0 ||
        bus.music_len !== 12'd0 || bus.playing !== 1'b0 || bus.note_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_init sel=%0d addr=%0d rd=%0d len=%0d play=%0b tick=%0b required all 0",
               bus.track_sel, bus.ram_addr_out, bus.rd_addr, bus.music_len, bus.playing, bus.note_tick);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_play_track0();
    bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    checks++;
    if (bus.playing !== 1'b0 || bus.note_tick !== 1'b0) begin
      failures++;
      $display("FAIL load_cycle playing=%0b tick=%0b required 0 0", bus.playing, bus.note_tick);
    end
    step();
    checks++;
    if (bus.note_tick !== 1'b1 || bus.ram_addr_out !== 12'd0 || bus.rd_addr !== 12'd0 ||
        bus.music_len !== 12'd8 || bus.playing !== 1'b1) begin
      failures++;
      $display("FAIL first_tick tick=%0b addr=%0d rd=%0d len=%0d play=%0b required 1 0 0 8 1",
               bus.note_tick, bus.ram_addr_out, bus.rd_addr, bus.music_len, bus.playing);
    end
    for (int k = 1; k <= 7; k++) begin
      repeat (9) step();
      checks++;
      if (bus.note_tick !== 1'b0) begin
        failures++;
        $display("FAIL early_tick step=%0d tick=%0b required 0", k, bus.note_tick);
      end
      step();
      checks++;
      if (bus.note_tick !== 1'b1 || bus.ram_addr_out !== 12'(k) || bus.rd_addr !== 12'(k)) begin
        failures++;
        $display("FAIL step_%0d tick=%0b addr=%0d rd=%0d required 1 %0d %0d",
                 k, bus.note_tick, bus.ram_addr_out, bus.rd_addr, k, k);
      end
    end
    repeat (10) step();
    checks++;
    if (bus.track_sel !== 2'd1 || bus.playing !== 1'b0) begin
      failures++;
      $display("FAIL end_track0 sel=%0d play=%0b required 1 0", bus.track_sel, bus.playing);
    end
    step();
    checks++;
    if (bus.rd_addr !== 12'd256 || bus.ram_addr_out !== 12'd0 || bus.note_tick !== 1'b1) begin
      failures++;
      $display("FAIL track1_load rd=%0d addr=%0d tick=%0b required 256 0 1",
               bus.rd_addr, bus.ram_addr_out, bus.note_tick);
    end
  endtask

  task automatic test_pause();
    int bad;
    int n;
    bad = 0;
    n = 0;
    repeat (24) step();
    bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    checks++;
    if (bus.playing !== 1'b0 || bus.ram_addr_out !== 12'd2) begin
      failures++;
      $display("FAIL pause_enter play=%0b addr=%0d required 0 2", bus.playing, bus.ram_addr_out);
    end
    repeat (100) begin
      step();
      if (bus.note_tick !== 1'b0 || bus.ram_addr_out !== 12'd2 || bus.playing !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL pause_hold bad_cycles=%0d required 0", bad);
    end
    bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    checks++;
    if (bus.playing !== 1'b1) begin
      failures++;
      $display("FAIL resume playing=%0b required 1", bus.playing);
    end
    do begin
      step();
      n++;
    end while (bus.note_tick !== 1'b1 && n < 20);
    checks++;
    if (n !== 5 || bus.ram_addr_out !== 12'd3) begin
      failures++;
      $display("FAIL resume_tick cycles=%0d addr=%0d required 5 3", n, bus.ram_addr_out);
    end
  endtask

  task automatic test_stop_next();
    bus.key_stop = 1'b1; bus.key_next = 1'b1; step(); bus.key_stop = 1'b0; bus.key_next = 1'b0;
    checks++;
    if (bus.playing !== 1'b0 || bus.track_sel !== 2'd1 || bus.ram_addr_out !== 12'd0 ||
        bus.rd_addr !== 12'd256 || bus.music_len !== 12'd8) begin
      failures++;
      $display("FAIL stop_next play=%0b sel=%0d addr=%0d rd=%0d len=%0d required 0 1 0 256 8",
               bus.playing, bus.track_sel, bus.ram_addr_out, bus.rd_addr, bus.music_len);
    end
  endtask

  task automatic test_zero_len();
    bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    step();
    checks++;
    if (bus.playing !== 1'b1 || bus.note_tick !== 1'b1) begin
      failures++;
      $display("FAIL replay_track1 play=%0b tick=%0b required 1 1", bus.playing, bus.note_tick);
    end
    repeat (3) step();
    bus.key_next = 1'b1; step(); bus.key_next = 1'b0;
    checks++;
    if (bus.track_sel !== 2'd2 || bus.playing !== 1'b0) begin
      failures++;
      $display("FAIL next_to_empty sel=%0d play=%0b required 2 0", bus.track_sel, bus.playing);
    end
    step();
    checks++;
    if (bus.note_tick !== 1'b0 || bus.music_len !== 12'd0 || bus.rd_addr !== 12'd512) begin
      failures++;
      $display("FAIL empty_load tick=%0b len=%0d rd=%0d required 0 0 512",
               bus.note_tick, bus.music_len, bus.rd_addr);
    end
    step();
    checks++;
    if (bus.playing !== 1'b0 || bus.note_tick !== 1'b0 || bus.track_sel !== 2'd2) begin
      failures++;
      $display("FAIL empty_idle play=%0b tick=%0b sel=%0d required 0 0 2",
               bus.playing, bus.note_tick, bus.track_sel);
    end
    bus.key_next = 1'b1; step(); bus.key_next = 1'b0;
    checks++;
    if (bus.track_sel !== 2'd3 || bus.playing !== 1'b0) begin
      failures++;
      $display("FAIL idle_next sel=%0d play=%0b required 3 0", bus.track_sel, bus.playing);
    end
  endtask

  task automatic test_last_track();
    int n;
    n = 0;
    bus.loop_en = 1'b0;
    bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    step();
    do begin
      step();
      n++;
    end while (bus.playing === 1'b1 && n < 200);
    checks++;
    if (n !== 80 || bus.track_sel !== 2'd0 || bus.ram_addr_out !== 12'd0) begin
      failures++;
      $display("FAIL last_track_end cycles=%0d sel=%0d addr=%0d required 80 0 0",
               n, bus.track_sel, bus.ram_addr_out);
    end
  endtask

  task automatic test_prev_idle();
    bus.key_prev = 1'b1; step(); bus.key_prev = 1'b0;
    checks++;
    if (bus.track_sel !== 2'd3) begin
      failures++;
      $display("FAIL prev_wrap sel=%0d required 3", bus.track_sel);
    end
  endtask

  task automatic test_loop();
    bus.loop_en = 1'b1;
    bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    step();
    repeat (80) step();
    checks++;
    if (bus.playing !== 1'b0 || bus.track_sel !== 2'd3 || bus.ram_addr_out !== 12'd7) begin
      failures++;
      $display("FAIL loop_reload play=%0b sel=%0d addr=%0d required 0 3 7",
               bus.playing, bus.track_sel, bus.ram_addr_out);
    end
    step();
    checks++;
    if (bus.ram_addr_out !== 12'd0 || bus.note_tick !== 1'b1 || bus.track_sel !== 2'd3 ||
        bus.rd_addr !== 12'd768) begin
      failures++;
      $display("FAIL loop_restart addr=%0d tick=%0b sel=%0d rd=%0d required 0 1 3 768",
               bus.ram_addr_out, bus.note_tick, bus.track_sel, bus.rd_addr);
    end
  endtask

  task automatic test_reset_midplay();
    repeat (50) step();
    checks++;
    if (bus.ram_addr_out !== 12'd5 || bus.playing !== 1'b1) begin
      failures++;
      $display("FAIL before_reset addr=%0d play=%0b required 5 1", bus.ram_addr_out, bus.playing);
    end
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.track_sel !== 2'd0 || bus.ram_addr_out !== 12'd0 || bus.rd_addr !== 12'd0 ||
        bus.music_len !== 12'd0 || bus.playing !== 1'b0 || bus.note_tick !== 1'b0) begin
      failures++;
      $display("FAIL async_reset sel=%0d addr=%0d rd=%0d len=%0d play=%0b tick=%0b required all 0",
               bus.track_sel, bus.ram_addr_out, bus.rd_addr, bus.music_len, bus.playing, bus.note_tick);
    end
    bus.loop_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    bus.key_play = 1'b1; step(); bus.key_play = 1'b0;
    checks++;
    if (bus.playing !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_load play=%0b required 0", bus.playing);
    end
    step();
    checks++;
    if (bus.playing !== 1'b1 || bus.note_tick !== 1'b1 || bus.rd_addr !== 12'd0 || bus.track_sel !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_play play=%0b tick=%0b rd=%0d sel=%0d required 1 1 0 0",
               bus.playing, bus.note_tick, bus.rd_addr, bus.track_sel);
    end
  endtask

  initial begin
    test_reset();
    test_play_track0();
    test_pause();
    test_stop_next();
    test_zero_len();
    test_last_track();
    test_prev_idle();
    test_loop();
    test_reset_midplay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
